// File: rtl/dna_bus_pkg.sv
// Shared definitions for the data-bus side of the load/store unit.
//
// Contents:
//   SZ_*            access size encodings used on the core request interface
//   AXI_*_WIDTH     AXI-Lite sideband widths
//   lsu_state_e     states of the AXI-Lite master sequencer
//   is_misaligned() alignment / legality check for a request
package dna_bus_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int AXI_RESP_WIDTH = 2;
    localparam int AXI_STRB_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_R,
        ST_RESP
    } lsu_state_e;

    // An access is rejected when its size is illegal or when the address
    // is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit data bus.
//
// Ports:
//   size_i        access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   addr_lo_i     address bits [1:0] selecting the starting byte lane
//   unsigned_i    zero-extend loads when 1, sign-extend when 0
//   store_data_i  right-aligned store data from the core
//   load_data_i   raw 32-bit word returned by the bus
//   wstrb_o       byte strobes for the store
//   wdata_o       store data replicated into every lane of its size
//   load_data_o   load data shifted down and extended to 32 bits
//
// Purely combinational so it can be shared with the future cache path.
module lsu_lane_align
    import dna_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    // Replicating the store data means the slave finds the right bytes in
    // whichever lane the strobes enable, so no data shifter is needed.
    always_comb begin
        shifted     = load_data_i >> {addr_lo_i, 3'b000};
        wstrb_o     = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = shifted;
        case (size_i)
            SZ_BYTE: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wstrb_o     = 4'b0011 << addr_lo_i;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                wstrb_o     = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = shifted;
            end
            default: begin
                wstrb_o     = 4'b0000;
                wdata_o     = 32'h0;
                load_data_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// Load/store unit front-end: turns single-outstanding core memory requests
// into AXI-Lite master transactions toward the data memory.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_cpu_req_*, o_cpu_req_ready   core request (we, size, unsigned, addr, wdata)
//   o_cpu_rsp_*           one-cycle response pulse with load data and error flag
//   o_axi_aw*/w*/b*       AXI-Lite write address, write data, write response
//   o_axi_ar*/r*          AXI-Lite read address, read data
//
// Misaligned or illegal-size requests answer with an error and never reach
// the bus. Any handshake that waits TIMEOUT_CYCLES cycles is abandoned and
// reported as an error.
module lsu_axi_lite_master
    import dna_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_cpu_req_valid,
    output logic                      o_cpu_req_ready,
    input  logic                      i_cpu_we,
    input  logic [1:0]                i_cpu_size,
    input  logic                      i_cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]     i_cpu_wdata,
    output logic                      o_cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0]     o_cpu_rsp_rdata,
    output logic                      o_cpu_rsp_err,
    output logic [ADDR_WIDTH-1:0]     o_axi_awaddr,
    output logic                      o_axi_awvalid,
    input  logic                      i_axi_awready,
    output logic [DATA_WIDTH-1:0]     o_axi_wdata,
    output logic [AXI_STRB_WIDTH-1:0] o_axi_wstrb,
    output logic                      o_axi_wvalid,
    input  logic                      i_axi_wready,
    input  logic                      i_axi_bvalid,
    output logic                      o_axi_bready,
    output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
    output logic                      o_axi_arvalid,
    input  logic                      i_axi_arready,
    input  logic [DATA_WIDTH-1:0]     i_axi_rdata,
    input  logic                      i_axi_rvalid,
    output logic                      o_axi_rready
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_fire;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  tmo_busy;
    logic                  tmo_expired;
    logic [3:0]            lane_wstrb;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_load;

    lsu_lane_align u_lane_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .store_data_i (wdata_q),
        .load_data_i  (i_axi_rdata),
        .wstrb_o      (lane_wstrb),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // Each AW/W valid falls independently once its own handshake is done.
    assign o_cpu_req_ready = (state_q == ST_IDLE);
    assign o_axi_awvalid   = (state_q == ST_WR) && !aw_done_q;
    assign o_axi_wvalid    = (state_q == ST_WR) && !w_done_q;
    assign o_axi_bready    = (state_q == ST_WR_B);
    assign o_axi_arvalid   = (state_q == ST_RD_A);
    assign o_axi_rready    = (state_q == ST_RD_R);
    assign o_axi_awaddr    = addr_q;
    assign o_axi_araddr    = addr_q;
    assign o_axi_wdata     = (state_q == ST_WR) ? lane_wdata : '0;
    assign o_axi_wstrb     = (state_q == ST_WR) ? lane_wstrb : '0;
    assign o_cpu_rsp_valid = (state_q == ST_RESP);
    assign o_cpu_rsp_rdata = rdata_q;
    assign o_cpu_rsp_err   = err_q;

    assign req_fire    = i_cpu_req_valid && o_cpu_req_ready;
    assign aw_fire     = o_axi_awvalid && i_axi_awready;
    assign w_fire      = o_axi_wvalid && i_axi_wready;
    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // A completing handshake wins over a timeout landing in the same cycle.
    // The address register is cleared only when RESP retires, so the slave
    // sees a stable address for the whole transaction.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tmo_busy   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    addr_d     = i_cpu_addr;
                    size_d     = i_cpu_size;
                    unsigned_d = i_cpu_unsigned;
                    wdata_d    = i_cpu_wdata;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    if (is_misaligned(i_cpu_size, i_cpu_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (i_cpu_we) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_WR: begin
                tmo_busy  = 1'b1;
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_B;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WR_B: begin
                tmo_busy = 1'b1;
                if (i_axi_bvalid) begin
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RD_A: begin
                tmo_busy = 1'b1;
                if (i_axi_arready) begin
                    state_d = ST_RD_R;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RD_R: begin
                tmo_busy = 1'b1;
                if (i_axi_rvalid) begin
                    rdata_d = lane_load;
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                addr_d  = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The counter restarts on every state change so each handshake
        // gets its own full budget.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (tmo_busy) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            tmo_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Directed testbench for lsu_axi_lite_master with a small AXI-Lite slave
// model whose per-channel wait states are set by each test.
module tb_lsu_axi_lite_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        cpuReqValid = 1'b0;
    logic        cpuReqReady;
    logic        cpuWe = 1'b0;
    logic [1:0]  cpuSize = 2'b00;
    logic        cpuUnsigned = 1'b0;
    logic [31:0] cpuAddr = 32'h0;
    logic [31:0] cpuWdata = 32'h0;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;

    logic [31:0] awAddr;
    logic        awValid;
    logic        awReady = 1'b0;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic        wValid;
    logic        wReady = 1'b0;
    logic        bValid = 1'b0;
    logic        bReady;
    logic [31:0] arAddr;
    logic        arValid;
    logic        arReady = 1'b0;
    logic [31:0] rData = 32'h0;
    logic        rValid = 1'b0;
    logic        rReady;

    // Slave model state and knobs
    logic [31:0] mem [0:255];
    int          awDelay = 1, wDelay = 1, bDelay = 0, arDelay = 1, rDelay = 0;
    int          awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
    logic        awGot = 1'b0, wGot = 1'b0, arGot = 1'b0;
    logic [31:0] awAddrGot = 32'h0, arAddrGot = 32'h0, wDataGot = 32'h0;
    logic [3:0]  wStrbGot = 4'h0;
    logic [7:0]  memIdx;
    int          awHigh = 0, wHigh = 0, arHigh = 0, unstable = 0, rspCount = 0;
    logic [31:0] expAddr = 32'h0, expWdata = 32'h0;
    logic [3:0]  expWstrb = 4'h0;

    // Results of the last request
    logic [31:0] gotData;
    logic        gotErr;
    int          latency;
    int          checkCount = 0;
    int          errorCount = 0;

    lsu_axi_lite_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clock),
        .reset           (reset),
        .i_cpu_req_valid (cpuReqValid),
        .o_cpu_req_ready (cpuReqReady),
        .i_cpu_we        (cpuWe),
        .i_cpu_size      (cpuSize),
        .i_cpu_unsigned  (cpuUnsigned),
        .i_cpu_addr      (cpuAddr),
        .i_cpu_wdata     (cpuWdata),
        .o_cpu_rsp_valid (rspValid),
        .o_cpu_rsp_rdata (rspRdata),
        .o_cpu_rsp_err   (rspErr),
        .o_axi_awaddr    (awAddr),
        .o_axi_awvalid   (awValid),
        .i_axi_awready   (awReady),
        .o_axi_wdata     (wData),
        .o_axi_wstrb     (wStrb),
        .o_axi_wvalid    (wValid),
        .i_axi_wready    (wReady),
        .i_axi_bvalid    (bValid),
        .o_axi_bready    (bReady),
        .o_axi_araddr    (arAddr),
        .o_axi_arvalid   (arValid),
        .i_axi_arready   (arReady),
        .i_axi_rdata     (rData),
        .i_axi_rvalid    (rValid),
        .o_axi_rready    (rReady)
    );

    always #5 clock = ~clock;

    // The slave acts on the falling edge: anything it raises there is seen
    // by the DUT on the next rising edge, so a ready raised while valid is
    // high is a handshake, and the ready is dropped on the following fall.
    // B and R are evaluated first so they only react to address/data
    // handshakes that have already completed.
    always @(negedge clock) begin
        if (reset) begin
            awReady = 1'b0; wReady = 1'b0; arReady = 1'b0;
            bValid = 1'b0; rValid = 1'b0; rData = 32'h0;
            awGot = 1'b0; wGot = 1'b0; arGot = 1'b0;
            awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
        end else begin
            if (bValid) begin
                bValid = 1'b0;
            end else if (awGot && wGot) begin
                if (bCnt >= bDelay) begin
                    memIdx = awAddrGot[9:2];
                    for (int i = 0; i < 4; i++)
                        if (wStrbGot[i]) mem[memIdx][8*i +: 8] = wDataGot[8*i +: 8];
                    bValid = 1'b1; awGot = 1'b0; wGot = 1'b0; bCnt = 0;
                end else bCnt++;
            end

            if (rValid) begin
                rValid = 1'b0; rData = 32'h0;
            end else if (arGot) begin
                if (rCnt >= rDelay) begin
                    rValid = 1'b1; rData = mem[arAddrGot[9:2]]; arGot = 1'b0; rCnt = 0;
                end else rCnt++;
            end

            if (awValid) begin
                awHigh++;
                if (awAddr !== expAddr) unstable++;
            end
            if (awReady) awReady = 1'b0;
            else if (awValid) begin
                if (awCnt >= awDelay) begin
                    awReady = 1'b1; awGot = 1'b1; awAddrGot = awAddr; awCnt = 0;
                end else awCnt++;
            end else awCnt = 0;

            if (wValid) begin
                wHigh++;
                if (wData !== expWdata || wStrb !== expWstrb) unstable++;
            end
            if (wReady) wReady = 1'b0;
            else if (wValid) begin
                if (wCnt >= wDelay) begin
                    wReady = 1'b1; wGot = 1'b1; wDataGot = wData; wStrbGot = wStrb; wCnt = 0;
                end else wCnt++;
            end else wCnt = 0;

            if (arValid) begin
                arHigh++;
                if (arAddr !== expAddr) unstable++;
            end
            if (arReady) arReady = 1'b0;
            else if (arValid) begin
                if (arCnt >= arDelay) begin
                    arReady = 1'b1; arGot = 1'b1; arAddrGot = arAddr; arCnt = 0;
                end else arCnt++;
            end else arCnt = 0;

            if (rspValid) rspCount++;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issues one request and waits (bounded) for its response pulse.
    // latency counts falling edges from the accepting clock edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] expWd, input logic [3:0] expSt);
        int guard;
        @(negedge clock);
        awHigh = 0; wHigh = 0; arHigh = 0; unstable = 0;
        expAddr = addr; expWdata = expWd; expWstrb = expSt;
        cpuWe = we; cpuSize = size; cpuUnsigned = uns; cpuAddr = addr; cpuWdata = wdata;
        cpuReqValid = 1'b1;
        guard = 0;
        while (!cpuReqReady && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("req_ready", 32'(cpuReqReady), 32'd1);
        @(negedge clock);
        cpuReqValid = 1'b0;
        latency = 1;
        while (!rspValid && latency < 60) begin
            @(negedge clock);
            latency++;
        end
        checkOutput("rsp_seen", 32'(rspValid), 32'd1);
        gotData = rspRdata;
        gotErr  = rspErr;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rspBefore;
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_ctrl", 32'({awValid, wValid, arValid, bReady, rReady, rspValid, rspErr}), 32'd0);
        checkOutput("rst_awaddr", awAddr, 32'h0);
        checkOutput("rst_araddr", arAddr, 32'h0);
        checkOutput("rst_wdata", wData, 32'h0);
        checkOutput("rst_wstrb", 32'(wStrb), 32'h0);
        checkOutput("rst_rdata", rspRdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle_req_ready", 32'(cpuReqReady), 32'd1);

        // Word store then load, zero-wait slave
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF);
        checkOutput("st_w_awaddr", awAddrGot, 32'h100);
        checkOutput("st_w_wstrb", 32'(wStrbGot), 32'hF);
        checkOutput("st_w_wdata", wDataGot, 32'hDEADBEEF);
        checkOutput("st_w_err", 32'(gotErr), 32'd0);
        checkOutput("st_w_rdata", gotData, 32'h0);
        checkOutput("st_w_lat", 32'(latency), 32'd4);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_w_data", gotData, 32'hDEADBEEF);
        checkOutput("ld_w_err", 32'(gotErr), 32'd0);
        checkOutput("ld_w_lat", 32'(latency), 32'd4);
        checkOutput("ld_w_araddr", arAddrGot, 32'h100);

        // Byte store with upper garbage, then signed/unsigned byte loads
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h103, 32'h123456A5, 32'hA5A5A5A5, 4'h8);
        checkOutput("st_b_wstrb", 32'(wStrbGot), 32'h8);
        checkOutput("st_b_wdata", wDataGot, 32'hA5A5A5A5);
        checkOutput("st_b_mem", mem[64], 32'hA5ADBEEF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_b_signed", gotData, 32'hFFFFFFA5);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_b_unsigned", gotData, 32'h000000A5);

        // Half and byte loads from a preset word
        mem[64] = 32'h80011234;
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_h_signed", gotData, 32'hFFFF8001);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_h_unsigned", gotData, 32'h00008001);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_h_low_pos", gotData, 32'h00001234);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0, 4'h0);
        checkOutput("ld_b_lane1", gotData, 32'h00000012);

        // Misaligned and illegal-size requests never reach the bus
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 4'h0);
        checkOutput("mis_h_err", 32'(gotErr), 32'd1);
        checkOutput("mis_h_lat", 32'(latency), 32'd1);
        checkOutput("mis_h_arvalid", 32'(arHigh), 32'd0);
        checkOutput("mis_h_rdata", gotData, 32'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h102, 32'h11111111, 32'h0, 4'h0);
        checkOutput("mis_w_err", 32'(gotErr), 32'd1);
        checkOutput("mis_w_lat", 32'(latency), 32'd1);
        checkOutput("mis_w_awvalid", 32'(awHigh + wHigh), 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0);
        checkOutput("ill_size_err", 32'(gotErr), 32'd1);
        checkOutput("ill_size_arvalid", 32'(arHigh), 32'd0);

        // Stalling slave: awready 3 cycles after wready, bvalid 5 cycles late
        awDelay = 4; wDelay = 1; bDelay = 5;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h108, 32'h55AA1234, 32'h55AA1234, 4'hF);
        checkOutput("stall_err", 32'(gotErr), 32'd0);
        checkOutput("stall_stable", 32'(unstable), 32'd0);
        checkOutput("stall_awhigh", 32'(awHigh), 32'd5);
        checkOutput("stall_whigh", 32'(wHigh), 32'd2);
        checkOutput("stall_lat", 32'(latency), 32'd12);
        checkOutput("stall_mem", mem[66], 32'h55AA1234);
        awDelay = 1; bDelay = 0;

        // Slave never accepts AR: timeout after 8 cycles
        arDelay = 1000;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0);
        checkOutput("tmo_err", 32'(gotErr), 32'd1);
        checkOutput("tmo_arhigh", 32'(arHigh), 32'd8);
        checkOutput("tmo_rdata", gotData, 32'h0);
        checkOutput("tmo_lat", 32'(latency), 32'd9);
        checkOutput("rsp_total", 32'(rspCount), 32'd14);

        // Reset in the middle of RD_R aborts without a response
        arDelay = 1; rDelay = 1000;
        @(negedge clock);
        expAddr = 32'h100;
        cpuWe = 1'b0; cpuSize = 2'b10; cpuUnsigned = 1'b0; cpuAddr = 32'h100;
        cpuReqValid = 1'b1;
        @(negedge clock);
        cpuReqValid = 1'b0;
        guard = 0;
        while (!rReady && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("mid_rd_r", 32'(rReady), 32'd1);
        rspBefore = rspCount;
        reset = 1'b1;
        #1;
        checkOutput("abort_ctrl", 32'({awValid, wValid, arValid, bReady, rReady, rspValid, rspErr}), 32'd0);
        checkOutput("abort_araddr", arAddr, 32'h0);
        checkOutput("abort_awaddr", awAddr, 32'h0);
        checkOutput("abort_rdata", rspRdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        arGot = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("abort_no_rsp", 32'(rspCount - rspBefore), 32'd0);
        checkOutput("abort_idle", 32'(cpuReqReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/lsu_axi_lite_master.md
Name: lsu_axi_lite_master

Overview:
- CPU load/store unit front-end: converts the core's single-outstanding load/store requests into AXI-Lite master transactions toward the data-memory slave.
- Performs byte-lane steering and strobe generation for stores, lane extraction and sign/zero extension for loads.
- Detects misaligned accesses and bus timeouts.
- Sits between the core's memory stage and the AXI-Lite data-memory port.

Parameters:
- ADDR_WIDTH, 32, AXI/CPU address width
- DATA_WIDTH, 32, data width; only 32 supported
- TIMEOUT_CYCLES, 255, max cycles waiting on any single handshake before abort; counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_cpu_req_valid  in  1  request present
- o_cpu_req_ready  out  1  request accepted this cycle
- i_cpu_we  in  1  1=store, 0=load
- i_cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_cpu_unsigned  in  1  load zero-extends when 1
- i_cpu_addr  in  ADDR_WIDTH  byte address
- i_cpu_wdata  in  DATA_WIDTH  store data, right-aligned
- o_cpu_rsp_valid  out  1  one-cycle completion pulse
- o_cpu_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- o_cpu_rsp_err  out  1  misaligned, illegal size, or timeout
- o_axi_awaddr, o_axi_awvalid, i_axi_awready  AW channel
- o_axi_wdata, o_axi_wstrb(4), o_axi_wvalid, i_axi_wready  W channel
- i_axi_bvalid, o_axi_bready  B channel
- o_axi_araddr, o_axi_arvalid, i_axi_arready  AR channel
- i_axi_rdata, i_axi_rvalid, o_axi_rready  R channel

Behaviour:
- Reset: all outputs 0 (valids, readies, addresses, wdata, wstrb, rsp_rdata, rsp_err). State IDLE, timeout counter 0. Reset mid-transaction aborts silently; no response is issued.
- o_cpu_req_ready is combinational: high only in IDLE. Request accepted on valid&&ready; all request fields are registered on acceptance.
- Alignment check at accept:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - Error: go to RESP with err=1 and issue no AXI traffic.
- Store lane steering:
  - wstrb: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - wdata: wdata replicated per size, i.e. byte {4{b}}, half {2{h}}, word as-is.
- States:
  - IDLE
  - WR: awvalid=wvalid=1. Drop each valid independently on its own ready. When both handshakes are done, go to WR_B.
  - WR_B: bready=1; bvalid -> RESP.
  - RD_A: arvalid=1; arready -> RD_R.
  - RD_R: rready=1; rvalid -> capture rdata, extract and extend -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Address hold: awaddr/araddr are driven from the accepted address from the cycle after acceptance until return to IDLE, because the slave samples araddr continuously. Both are cleared to 0 in IDLE only after RESP.
- Load extraction:
  - Shift right by 8*addr[1:0].
  - Byte: take [7:0], sign-extend bit7 unless unsigned.
  - Half: take [15:0], sign-extend bit15 unless unsigned.
  - Word: unchanged.
- Latency: with a zero-wait slave (ready asserted the cycle after valid), request-accept to rsp_valid is at least 4 cycles for both loads and stores. Misaligned requests respond in the cycle after accept.
- Simultaneous awready and wready in the same cycle is legal and goes to WR_B in one step. Either order of the two readies is also legal.
- Timeout:
  - Counter clears on every state entry and increments each cycle in WR, WR_B, RD_A, RD_R.
  - On reaching TIMEOUT_CYCLES: deassert all AXI valids/readies, go to RESP with err=1.
- A bvalid or rvalid arriving while not expected is ignored; bready/rready stay 0 outside WR_B/RD_R.
- Single outstanding transaction; no read/write overlap.

Decomposition:
- Shared package (dna_bus_pkg):
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state localparams
  - AXI response width constants
- Sub-module lsu_lane_align: combinational strobe/wdata replication plus load extract/extend. It is reused by the future cache path.

Test Plan:
- Store word 0xDEADBEEF to 0x100, zero-wait slave -> AW/W at 0x100, wstrb 1111, wdata 0xDEADBEEF; rsp_valid pulse, err=0; following load returns 0xDEADBEEF.
- Store byte 0xA5 to 0x103 -> wstrb 1000, wdata 0xA5A5A5A5. Signed byte load from 0x103 -> 0xFFFFFFA5; unsigned load -> 0x000000A5.
- Half load from 0x102 with memory 0x8001_1234 -> signed 0xFFFF8001, unsigned 0x00008001.
- Half load at 0x101 and word store at 0x102 -> rsp_valid with err=1 the cycle after accept; awvalid/arvalid never asserted.
- Slave stalls: awready delayed 3 cycles after wready, then bvalid delayed 5 cycles -> addr/data held stable throughout; single response, err=0.
- Slave never asserts arready, TIMEOUT_CYCLES=8 -> arvalid drops after 8 cycles, rsp err=1. Then assert reset mid-RD_R on the next load -> all outputs 0 and no response pulse.
